payload_char_feeder: RTL



---
 rtl/payload_feeder_pkg.sv | 24 ++
 rtl/char_class_table.sv | 54 +++++
 rtl/payload_char_feeder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/payload_feeder_pkg.sv
// Shared defaults, FSM state type and the ASCII case-fold helper for the payload character feeder.
// The case-fold helper is only referenced when CHAR_CASE_FOLD_EN is defined.
package payload_feeder_pkg;

    localparam int DEFAULT_DATA_W    = 64;
    localparam int DEFAULT_NUM_CLASS = 48;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SOD    = 2'd1,
        STREAM = 2'd2
    } feeder_state_t;

    // Swaps A-Z with a-z; every other byte maps to itself.
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) begin
            return b + 8'h20;
        end else if (b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
        return b;
    endfunction

endpackage

// File: rtl/char_class_table.sv
// 256-row character-class table: one write port, one registered read port (zero when not enabled).
// With CHAR_CASE_FOLD_EN the read also ORs in the masked row of the case-folded byte.
module char_class_table
    import payload_feeder_pkg::*;
#(
    parameter int NUM_CLASS = DEFAULT_NUM_CLASS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [7:0]           wr_char_i,
    input  logic [NUM_CLASS-1:0] wr_row_i,
    input  logic                 rd_en_i,
    input  logic [7:0]           rd_char_i,
`ifdef CHAR_CASE_FOLD_EN
    input  logic [NUM_CLASS-1:0] nocase_mask_i,
`endif
    output logic [NUM_CLASS-1:0] rd_class_o
);

    logic [NUM_CLASS-1:0] tbl_q [256];
    logic [NUM_CLASS-1:0] rd_class_q;
    logic [NUM_CLASS-1:0] lookup;

    // Rows must be clearable by reset, so this is a register array rather than a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            tbl_q[wr_char_i] <= wr_row_i;
        end
    end

    always_comb begin
`ifdef CHAR_CASE_FOLD_EN
        lookup = tbl_q[rd_char_i] | (nocase_mask_i & tbl_q[fold_case(rd_char_i)]);
`else
        lookup = tbl_q[rd_char_i];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_class_q <= '0;
        end else begin
            rd_class_q <= rd_en_i ? lookup : '0;
        end
    end

    assign rd_class_o = rd_class_q;

endmodule

// File: rtl/payload_char_feeder.sv
// Serialises payload words to one byte per cycle with sod/en/eod strobes and per-byte class lookup.
// Optional CHAR_CASE_FOLD_EN adds the nocase_mask input for case-insensitive class matching.
module payload_char_feeder
    import payload_feeder_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_CLASS = DEFAULT_NUM_CLASS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic [DATA_W/8-1:0]   s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    input  logic                  cfg_we,
    input  logic [7:0]            cfg_char,
    input  logic [NUM_CLASS-1:0]  cfg_row,
`ifdef CHAR_CASE_FOLD_EN
    input  logic [NUM_CLASS-1:0]  nocase_mask,
`endif
    output logic                  sod,
    output logic                  en,
    output logic                  eod,
    output logic [7:0]            char_byte,
    output logic [NUM_CLASS-1:0]  char_class
);

    localparam int NB = DATA_W / 8;
    localparam int PW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(NB + 1);

    function automatic logic [CW-1:0] count_keep(input logic [NB-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NB; i++) begin
            c = c + CW'(k[i]);
        end
        return c;
    endfunction

    feeder_state_t      state_q;
    logic [DATA_W-1:0]  buf_data_q;
    logic [NB-1:0]      buf_keep_q;
    logic               buf_last_q;
    logic [PW-1:0]      pos_q;
    logic               done_q;

    // Stage A: the slot chosen for this cycle (byte select and slot type).
    logic               a_sod_q;
    logic               a_en_q;
    logic               a_eod_q;
    logic [7:0]         a_byte_q;

    // Stage B: registered outputs, aligned with the table read.
    logic               b_sod_q;
    logic               b_en_q;
    logic               b_eod_q;
    logic [7:0]         b_byte_q;

    logic               accept;
    logic               from_buf;
    logic [7:0]         src_byte0;
    logic [NB-1:0]      src_keep;
    logic               src_last;
    logic [CW-1:0]      src_cnt;
    logic               first_final;
    logic [CW-1:0]      buf_cnt;
    logic [PW-1:0]      nxt_pos;
    logic [7:0]         nxt_byte;
    logic               nxt_final;

    assign s_tready = !rst && ((state_q == IDLE) || (state_q == STREAM && done_q));
    assign accept   = s_tvalid && s_tready;

    // The first slot of a word comes from the buffer right after SOD, otherwise straight off the bus.
    assign from_buf    = (state_q == SOD);
    assign src_byte0   = from_buf ? buf_data_q[7:0] : s_tdata[7:0];
    assign src_keep    = from_buf ? buf_keep_q : s_tkeep;
    assign src_last    = from_buf ? buf_last_q : s_tlast;
    assign src_cnt     = count_keep(src_keep);
    assign first_final = (src_cnt <= CW'(1));

    assign buf_cnt   = count_keep(buf_keep_q);
    assign nxt_pos   = pos_q + PW'(1);
    assign nxt_final = (CW'(nxt_pos) + CW'(1)) >= buf_cnt;

    always_comb begin
        nxt_byte = '0;
        for (int i = 0; i < NB; i++) begin
            if (nxt_pos == PW'(i)) begin
                nxt_byte = buf_data_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_data_q <= '0;
            buf_keep_q <= '0;
            buf_last_q <= 1'b0;
            pos_q      <= '0;
            done_q     <= 1'b0;
            a_sod_q    <= 1'b0;
            a_en_q     <= 1'b0;
            a_eod_q    <= 1'b0;
            a_byte_q   <= '0;
        end else begin
            a_sod_q  <= 1'b0;
            a_en_q   <= 1'b0;
            a_eod_q  <= 1'b0;
            a_byte_q <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        buf_data_q <= s_tdata;
                        buf_keep_q <= s_tkeep;
                        buf_last_q <= s_tlast;
                        done_q     <= 1'b0;
                        a_sod_q    <= 1'b1;
                        state_q    <= SOD;
                    end
                end
                SOD, STREAM: begin
                    if (state_q == SOD || (done_q && accept)) begin
                        if (state_q == STREAM) begin
                            buf_data_q <= s_tdata;
                            buf_keep_q <= s_tkeep;
                            buf_last_q <= s_tlast;
                        end
                        // An all-zero keep still takes one slot: empty, or eod-only on a last word.
                        pos_q    <= '0;
                        a_en_q   <= (src_cnt != '0);
                        a_byte_q <= (src_cnt != '0) ? src_byte0 : 8'h00;
                        a_eod_q  <= src_last && first_final;
                        done_q   <= first_final;
                        state_q  <= (src_last && first_final) ? IDLE : STREAM;
                    end else if (!done_q) begin
                        pos_q    <= nxt_pos;
                        a_en_q   <= 1'b1;
                        a_byte_q <= nxt_byte;
                        a_eod_q  <= buf_last_q && nxt_final;
                        done_q   <= nxt_final;
                        if (buf_last_q && nxt_final) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_sod_q  <= 1'b0;
            b_en_q   <= 1'b0;
            b_eod_q  <= 1'b0;
            b_byte_q <= '0;
        end else begin
            b_sod_q  <= a_sod_q;
            b_en_q   <= a_en_q;
            b_eod_q  <= a_eod_q;
            b_byte_q <= a_en_q ? a_byte_q : 8'h00;
        end
    end

    char_class_table #(
        .NUM_CLASS (NUM_CLASS)
    ) u_table (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (cfg_we),
        .wr_char_i     (cfg_char),
        .wr_row_i      (cfg_row),
        .rd_en_i       (a_en_q),
        .rd_char_i     (a_byte_q),
`ifdef CHAR_CASE_FOLD_EN
        .nocase_mask_i (nocase_mask),
`endif
        .rd_class_o    (char_class)
    );

    assign sod       = b_sod_q;
    assign en        = b_en_q;
    assign eod       = b_eod_q;
    assign char_byte = b_byte_q;

endmodule
